// File: rtl/exec_pkg.sv
// Shared definitions for the exec_muldiv HI/LO multiply-divide unit:
// op encodings, FSM state type and operand sign helper.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module muldiv_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] divisor_ext;

  assign shifted     = {rem_i, bit_i};
  assign divisor_ext = {1'b0, divisor_i};
  assign q_bit_o     = (shifted >= divisor_ext);
  // A successful subtract always leaves a remainder below the divisor, so it fits DATA_W bits.
  assign rem_o       = q_bit_o ? DATA_W'(shifted - divisor_ext) : shifted[DATA_W-1:0];

endmodule

// File: rtl/exec_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define EXEC_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module exec_muldiv
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [DATA_W-1:0] mq_q, mq_d;     // multiplier -> product low half / dividend -> quotient
  logic [DATA_W-1:0] md_q, md_d;     // multiplicand / divisor magnitude
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic              is_div_q, is_div_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              signed_op;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] div_rem;
  logic              div_q_bit;
  logic [2*DATA_W-1:0] prod_mag, prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  assign signed_op = is_signed_op(op);
  assign abs_a     = (signed_op && a[DATA_W-1]) ? -a : a;
  assign abs_b     = (signed_op && b[DATA_W-1]) ? -b : b;

  assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : '0);

  muldiv_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_i     (acc_q),
    .bit_i     (mq_q[DATA_W-1]),
    .divisor_i (md_q),
    .rem_o     (div_rem),
    .q_bit_o   (div_q_bit)
  );

  assign prod_mag = {acc_q, mq_q};
  assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
  assign quo_fix  = div0_q ? '1 : (neg_res_q ? -mq_q : mq_q);
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

`ifdef EXEC_MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] fast_prod;
  assign fast_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif

  always_comb begin
    // NOTE: every _d takes its hold value first so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    md_d      = md_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              md_d      = abs_b;
              cnt_d     = '0;
              neg_res_d = signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              is_div_d  = 1'b0;
              busy_d    = 1'b1;
`ifdef EXEC_MULDIV_FAST_MUL_EN
              {acc_d, mq_d} = fast_prod;
              state_d       = FIX;
`else
              acc_d   = '0;
              mq_d    = abs_a;
              state_d = MUL;
`endif
            end
            OP_DIV, OP_DIVU: begin
              acc_d     = '0;
              mq_d      = abs_a;
              md_d      = abs_b;
              cnt_d     = '0;
              neg_res_d = signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
              neg_rem_d = signed_op && a[DATA_W-1];
              div0_d    = (b == '0);
              is_div_d  = 1'b1;
              busy_d    = 1'b1;
              state_d   = DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mul_sum[DATA_W:1];
        mq_d  = {mul_sum[0], mq_q[DATA_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      DIV: begin
        acc_d = div_rem;
        mq_d  = {mq_q[DATA_W-2:0], div_q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including the FIX write.
    if (busy_q && cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      md_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      md_q      <= md_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Scoreboard bench for exec_muldiv (DATA_W=32): stimulus pushes expected HI/LO
// and completion cycle, an independent monitor checks every done pulse.
module tb_exec_muldiv;
  import exec_pkg::*;

  localparam int DW      = 32;
  localparam int DIV_LAT = DW + 1;
`ifdef EXEC_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = DW + 1;
`endif

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    int            due;
    string         name;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op    = 3'b000;
  logic [DW-1:0] a     = '0;
  logic [DW-1:0] b     = '0;
  logic          cancel = 1'b0;
  logic          busy, done;
  logic [DW-1:0] hi, lo;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  exec_muldiv #(.DATA_W(DW)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && done) begin
      check("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Called at a negedge; drives one start pulse accepted at the next posedge.
  task automatic issue(input string name, input op_e o, input logic [DW-1:0] va,
                       input logic [DW-1:0] vb, input logic [DW-1:0] ehi,
                       input logic [DW-1:0] elo, input int lat, input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    if (push) begin
      e.hi   = ehi;
      e.lo   = elo;
      e.due  = cyc + 1 + lat;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic run(input string name, input op_e o, input logic [DW-1:0] va,
                     input logic [DW-1:0] vb, input logic [DW-1:0] ehi,
                     input logic [DW-1:0] elo, input int lat);
    issue(name, o, va, vb, ehi, elo, lat, 1'b1);
    wait_done(name);
  endtask

  task automatic move_to(input string name, input op_e o, input logic [DW-1:0] v,
                         input logic [DW-1:0] ehi, input logic [DW-1:0] elo);
    issue(name, o, v, '0, '0, '0, 0, 1'b0);
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Arithmetic vectors, each started in the cycle the previous done is high.
    run("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT);
    run("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT);
    run("mult_m1m1",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_LAT);
    run("multu_2p32", OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MUL_LAT);
    run("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
    run("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);
    run("div_negb",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT);
    run("divu_100_7", OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DIV_LAT);
    run("divu_by0",   OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, DIV_LAT);
    @(negedge clock);
    check("after_done_pulse", 64'(done), 64'd0);

    // Register moves; cancel alongside a start in IDLE must not block it.
    move_to("mthi", OP_MTHI, 32'hAAAA0000, 32'hAAAA0000, 32'hFFFFFFFF);
    cancel = 1'b1;
    move_to("mtlo_cancel", OP_MTLO, 32'h00005555, 32'hAAAA0000, 32'h00005555);
    cancel = 1'b0;

    // Start during a DIV is ignored; cancel then aborts without a done pulse.
    issue("div_cancel", OP_DIV, 32'd1000, 32'd3, '0, '0, 0, 1'b0);
    repeat (3) @(negedge clock);
    issue("mthi_busy", OP_MTHI, 32'h00001234, '0, '0, '0, 0, 1'b0);
    check("ignored_hi", 64'(hi), 64'hAAAA0000);
    check("ignored_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_done", 64'(done), 64'd0);
    check("cancel_hi", 64'(hi), 64'hAAAA0000);
    check("cancel_lo", 64'(lo), 64'h00005555);
    repeat (40) @(negedge clock);
    check("cancel_lo_late", 64'(lo), 64'h00005555);

    // Asynchronous reset around iteration 10 of a MULT.
    issue("mult_reset", OP_MULT, 32'd12345, 32'd678, '0, '0, 0, 1'b0);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    move_to("mtlo_cafe", OP_MTLO, 32'h0000CAFE, 32'h00000000, 32'h0000CAFE);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
